// File: rtl/regbank_wr_arbiter_if.sv
// Requester-to-arbiter bus for the register bank write arbiter.
// The lock vector only exists when REGBANK_ARB_LOCK_EN is defined.
interface regbank_wr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
`ifdef REGBANK_ARB_LOCK_EN
  logic [NREQ-1:0]       lock;
`endif
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [DEPTH-1:0]      reg_en;
  logic [WIDTH-1:0]      reg_d;
  logic                  busy;
  logic [IDW-1:0]        last_id;

`ifdef REGBANK_ARB_LOCK_EN
  modport master (output req, addr, wdata, lock,
                  input  gnt, done, reg_en, reg_d, busy, last_id);
  modport slave  (input  req, addr, wdata, lock,
                  output gnt, done, reg_en, reg_d, busy, last_id);
`else
  modport master (output req, addr, wdata,
                  input  gnt, done, reg_en, reg_d, busy, last_id);
  modport slave  (input  req, addr, wdata,
                  output gnt, done, reg_en, reg_d, busy, last_id);
`endif
endinterface

// File: rtl/regbank_wr_arbiter.sv
// Round-robin write arbiter driving a one-hot enable bank with a req/done handshake.
// Define REGBANK_ARB_LOCK_EN to allow a locked winner to burst back-to-back writes.
module regbank_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic             clk,
  input logic             rst,
  regbank_wr_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, DONE} state_t;

  state_t           state, state_n;
  logic [NREQ-1:0]  gnt_q, gnt_n;
  logic [NREQ-1:0]  done_q, done_n;
  logic [DEPTH-1:0] reg_en_q, reg_en_n;
  logic [WIDTH-1:0] reg_d_q, reg_d_n;
  logic [AW-1:0]    addr_q, addr_n;
  logic [IDW-1:0]   last_id_q, last_id_n;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_n;
  logic             found;
  logic [IDW-1:0]   pick;

  // First requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt_q;
    done_n    = done_q;
    reg_en_n  = '0;
    reg_d_n   = reg_d_q;
    addr_n    = addr_q;
    last_id_n = last_id_q;
    rr_ptr_n  = rr_ptr_q;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_n       = GRANT;
          gnt_n         = '0;
          gnt_n[pick]   = 1'b1;
          addr_n        = bus.addr[int'(pick)*AW +: AW];
          reg_d_n       = bus.wdata[int'(pick)*WIDTH +: WIDTH];
          last_id_n     = pick;
          rr_ptr_n      = IDW'((int'(pick) + 1) % NREQ);
        end
      end
      GRANT: begin
        state_n = WRITE;
        // An address beyond the bank matches no enable, so the write is dropped.
        for (int i = 0; i < DEPTH; i++) begin
          if (int'(addr_q) == i) reg_en_n[i] = 1'b1;
        end
      end
      WRITE: begin
        state_n           = DONE;
        done_n            = '0;
        done_n[last_id_q] = 1'b1;
      end
      DONE: begin
        if (!bus.req[last_id_q]) begin
          state_n = IDLE;
          gnt_n   = '0;
          done_n  = '0;
        end
`ifdef REGBANK_ARB_LOCK_EN
        else if (bus.lock[last_id_q]) begin
          state_n = GRANT;
          done_n  = '0;
          addr_n  = bus.addr[int'(last_id_q)*AW +: AW];
          reg_d_n = bus.wdata[int'(last_id_q)*WIDTH +: WIDTH];
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      reg_en_q  <= '0;
      reg_d_q   <= '0;
      addr_q    <= '0;
      last_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      state     <= state_n;
      gnt_q     <= gnt_n;
      done_q    <= done_n;
      reg_en_q  <= reg_en_n;
      reg_d_q   <= reg_d_n;
      addr_q    <= addr_n;
      last_id_q <= last_id_n;
      rr_ptr_q  <= rr_ptr_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.reg_en  = reg_en_q;
  assign bus.reg_d   = reg_d_q;
  assign bus.busy    = (state != IDLE);
  assign bus.last_id = last_id_q;
endmodule
